// File: rtl/router_ingress_buffer.sv
// router_ingress_buffer
// Store-and-forward byte FIFO sitting directly upstream of the router input
// port. Host bytes are queued with their destination/type tags, and each
// complete packet is replayed using a valid/ready/eop handshake. A minimum
// idle gap is inserted after every packet. Packets longer than MAX_LEN are
// split: the MAX_LEN-th byte has its last bit forced.
//
// Build option: ROUTER_INGRESS_CUT_THROUGH_EN
//   undefined : a packet is sent only once it is completely buffered.
//   defined   : sending starts as soon as any byte is buffered. out_valid
//               drops while the FIFO is empty mid-packet.
//
// state | meaning
// IDLE  | waiting for something to send, out_valid=0
// SEND  | replaying head entries until the eop transfer
// GAP   | enforced idle cycles after an eop transfer, out_valid=0
module router_ingress_buffer #(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 4,
  parameter int MIN_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_wr,
  input  logic [1:0] host_dest,
  input  logic [1:0] host_type,
  input  logic [7:0] host_data,
  input  logic       host_last,
  output logic       host_full,
  output logic       overflow_err,
  output logic       oversize_err,
  output logic       out_valid,
  output logic [1:0] out_dest_addr,
  output logic [1:0] out_packet_type,
  output logic [7:0] out_payload,
  output logic       out_eop,
  input  logic       out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam bit HAS_GAP = (MIN_GAP > 0);
  localparam logic [1:0] GAP_INIT = HAS_GAP ? 2'(MIN_GAP - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] wr_len;
  logic [1:0]    gap_cnt;
  logic [12:0]   head;
  logic          wr_en;
  logic          pop;
  logic          eop_xfer;
  logic          len_hit;
  logic          force_last;
  logic          stored_last;
  logic          fifo_nonempty;
  logic          start_ok;

  // Entry layout: {dest[12:11], type[10:9], last[8], data[7:0]}
  assign head          = mem[rd_ptr];
  assign host_full     = (count == CW'(DEPTH));
  assign wr_en         = host_wr && !host_full;
  assign pop           = out_valid && out_ready;
  assign eop_xfer      = pop && head[8];
  assign fifo_nonempty = (count != '0);
  assign len_hit       = (wr_len == LW'(MAX_LEN - 1));
  assign force_last    = len_hit && !host_last;
  assign stored_last   = host_last || len_hit;

`ifdef ROUTER_INGRESS_CUT_THROUGH_EN
  assign out_valid = (state == SEND) && fifo_nonempty;
  assign start_ok  = fifo_nonempty;
`else
  logic [CW-1:0] pkt_cnt;

  assign out_valid = (state == SEND);
  assign start_ok  = (pkt_cnt != '0);

  // Number of complete packets held in the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_en && stored_last, eop_xfer})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
`endif

  // Data fields are only driven while valid so the router never sees stale bytes
  assign out_dest_addr   = out_valid ? head[12:11] : 2'b0;
  assign out_packet_type = out_valid ? head[10:9]  : 2'b0;
  assign out_eop         = out_valid ? head[8]     : 1'b0;
  assign out_payload     = out_valid ? head[7:0]   : 8'h00;

  // Storage array; contents are discarded logically by the pointer reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {host_dest, host_type, stored_last, host_data};
  end

  // FIFO pointers, occupancy and in-progress packet length
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_len <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        wr_len <= stored_last ? '0 : wr_len + LW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered one-cycle error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      overflow_err <= host_wr && host_full;
      oversize_err <= wr_en && force_last;
    end
  end

  // Packet replay sequencer with down-counting inter-packet gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) state <= SEND;
        end
        SEND: begin
          if (eop_xfer) begin
            if (HAS_GAP) begin
              state   <= GAP;
              gap_cnt <= GAP_INIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 2'd0) state <= IDLE;
          else gap_cnt <= gap_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ingress_buffer.sv
// Testbench for router_ingress_buffer: directed scenarios plus a randomized
// run checked against a queue-based model of the buffer.
`timescale 1ns/1ps
module tb_router_ingress_buffer;
  localparam int DEPTH   = 16;
  localparam int MAX_LEN = 4;
  localparam int MIN_GAP = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_wr;
  logic [1:0] host_dest;
  logic [1:0] host_type;
  logic [7:0] host_data;
  logic       host_last;
  logic       host_full;
  logic       overflow_err;
  logic       oversize_err;
  logic       out_valid;
  logic [1:0] out_dest_addr;
  logic [1:0] out_packet_type;
  logic [7:0] out_payload;
  logic       out_eop;
  logic       out_ready;

  int errors = 0;
  int checks = 0;
  logic [12:0] rx_q[$];

  router_ingress_buffer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .reset(reset),
    .host_wr(host_wr), .host_dest(host_dest), .host_type(host_type),
    .host_data(host_data), .host_last(host_last),
    .host_full(host_full), .overflow_err(overflow_err), .oversize_err(oversize_err),
    .out_valid(out_valid), .out_dest_addr(out_dest_addr),
    .out_packet_type(out_packet_type), .out_payload(out_payload),
    .out_eop(out_eop), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host_wr = 0; host_dest = 0; host_type = 0; host_data = 0; host_last = 0;
    out_ready = 0;
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic write_byte(input logic [1:0] d, input logic [1:0] t,
                            input logic [7:0] data, input logic last);
    host_wr = 1; host_dest = d; host_type = t; host_data = data; host_last = last;
    cycle();
    host_wr = 0; host_last = 0;
  endtask

  // Gathers up to n transferred entries with out_ready held high
  task automatic collect(input int n, input int budget);
    rx_q.delete();
    out_ready = 1;
    for (int i = 0; i < budget && rx_q.size() < n; i++) begin
      if (out_valid) rx_q.push_back({out_dest_addr, out_packet_type, out_eop, out_payload});
      cycle();
    end
    out_ready = 0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    do_reset();
    obs = {host_full, overflow_err, oversize_err, out_valid, out_dest_addr,
           out_packet_type, out_payload, out_eop};
    checks++;
    if (obs !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0000", obs);
    end
    checks++;
    if (dut.count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", dut.count);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_data[3];
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    do_reset();
    out_ready = 1;
    write_byte(2'd2, 2'd1, 8'h11, 1'b0);
    write_byte(2'd2, 2'd1, 8'h22, 1'b0);
    write_byte(2'd2, 2'd1, 8'h33, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early_valid: got %b expected 0", out_valid);
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_dest_addr, out_packet_type, out_payload, out_eop} !==
          {1'b1, 2'd2, 2'd1, exp_data[i], (i == 2)}) begin
        errors++;
        $display("FAIL single_byte%0d: got v=%b d=%0d t=%0d p=%h e=%b expected v=1 d=2 t=1 p=%h e=%b",
                 i, out_valid, out_dest_addr, out_packet_type, out_payload, out_eop,
                 exp_data[i], (i == 2));
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_after_eop: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [8:0] held;
    logic [7:0] got[$];
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++) write_byte(2'd1, 2'd3, 8'hA0 + 8'(i), (i == 3));
    for (int i = 0; i < 5 && !out_valid; i++) cycle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_start: got valid=%b expected 1", out_valid);
    end
    out_ready = 1;
    got.push_back(out_payload);
    cycle();
    out_ready = 0;
    held = {out_payload, out_eop};
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({out_valid, out_payload, out_eop} !== {1'b1, held}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b p=%h e=%b expected v=1 p=%h e=%b",
                 i, out_valid, out_payload, out_eop, held[8:1], held[0]);
      end
    end
    collect(3, 12);
    foreach (rx_q[i]) got.push_back(rx_q[i][7:0]);
    checks++;
    if (got.size() != 4 || rx_q.size() != 3) begin
      errors++; $display("FAIL stall_count: got %0d bytes expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 8'hA0 + 8'(i)) begin
          errors++; $display("FAIL stall_data%0d: got %h expected %h", i, got[i], 8'hA0 + 8'(i));
        end
      end
      checks++;
      if ({rx_q[0][8], rx_q[1][8], rx_q[2][8]} !== 3'b001) begin
        errors++; $display("FAIL stall_eop: got %b expected 001",
                           {rx_q[0][8], rx_q[1][8], rx_q[2][8]});
      end
    end
  endtask

  task automatic test_oversize();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      write_byte(2'd3, 2'd2, 8'h51 + 8'(i), 1'b0);
      checks++;
      if (oversize_err !== (i == 3)) begin
        errors++; $display("FAIL oversize_pulse%0d: got %b expected %b", i, oversize_err, (i == 3));
      end
    end
    collect(4, 20);
    checks++;
    if (rx_q.size() != 4) begin
      errors++; $display("FAIL oversize_first_len: got %0d expected 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i] !== {2'd3, 2'd2, (i == 3), 8'h51 + 8'(i)}) begin
          errors++; $display("FAIL oversize_first%0d: got %h expected %h", i, rx_q[i],
                             {2'd3, 2'd2, (i == 3), 8'h51 + 8'(i)});
        end
      end
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL oversize_partial_held: got valid=%b expected 0", out_valid);
    end
    out_ready = 0;
    write_byte(2'd3, 2'd2, 8'h57, 1'b1);
    collect(3, 20);
    checks++;
    if (rx_q.size() != 3) begin
      errors++; $display("FAIL oversize_second_len: got %0d expected 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== {2'd3, 2'd2, (i == 2), 8'h55 + 8'(i)}) begin
          errors++; $display("FAIL oversize_second%0d: got %h expected %h", i, rx_q[i],
                             {2'd3, 2'd2, (i == 2), 8'h55 + 8'(i)});
        end
      end
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(2'd1, 2'd0, 8'(i), 1'b1);
      if (i == DEPTH - 2) begin
        checks++;
        if (host_full !== 1'b0) begin
          errors++; $display("FAIL full_early: got %b expected 0", host_full);
        end
      end
    end
    checks++;
    if (host_full !== 1'b1) begin
      errors++; $display("FAIL full_set: got %b expected 1", host_full);
    end
    write_byte(2'd1, 2'd0, 8'hEE, 1'b1);
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++; $display("FAIL overflow_pulse: got %b expected 1", overflow_err);
    end
    cycle();
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++; $display("FAIL overflow_one_cycle: got %b expected 0", overflow_err);
    end
    collect(DEPTH + 1, 200);
    checks++;
    if (rx_q.size() != DEPTH) begin
      errors++; $display("FAIL full_drain_count: got %0d expected %0d", rx_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (rx_q[i] !== {2'd1, 2'd0, 1'b1, 8'(i)}) begin
          errors++; $display("FAIL full_drain%0d: got %h expected %h", i, rx_q[i],
                             {2'd1, 2'd0, 1'b1, 8'(i)});
        end
      end
    end
  endtask

  task automatic test_gap_reset();
    logic [7:0] wd[4];
    int eop_idx = -1;
    int next_idx = -1;
    bit did_reset = 0;
    wd[0] = 8'h61; wd[1] = 8'h62; wd[2] = 8'h71; wd[3] = 8'h72;
    do_reset();
    out_ready = 1;
    for (int c = 0; c < 40 && !did_reset; c++) begin
      if (out_valid) begin
        if (out_eop && out_payload == 8'h62) eop_idx = c;
        if (out_payload == 8'h71 && next_idx < 0) next_idx = c;
        if (out_payload == 8'h72) begin
          reset = 1;
          did_reset = 1;
        end
      end
      if (c < 4) begin
        host_wr = 1; host_dest = 2'd0; host_type = 2'd2; host_data = wd[c];
        host_last = (c == 1 || c == 3);
      end else begin
        host_wr = 0; host_last = 0;
      end
      cycle();
    end
    reset = 0;
    checks++;
    if (!did_reset || eop_idx < 0 || next_idx < 0) begin
      errors++; $display("FAIL gap_timeout: got eop=%0d next=%0d reset=%0d expected all seen",
                         eop_idx, next_idx, did_reset);
    end else begin
      checks++;
      if (next_idx - eop_idx != MIN_GAP + 2) begin
        errors++; $display("FAIL gap_length: got %0d expected %0d", next_idx - eop_idx, MIN_GAP + 2);
      end
    end
    checks++;
    if ({out_valid, out_dest_addr, out_packet_type, out_payload, out_eop,
         host_full, overflow_err, oversize_err} !== 16'h0) begin
      errors++; $display("FAIL gap_reset_outputs: got v=%b p=%h expected all 0", out_valid, out_payload);
    end
    checks++;
    if (dut.count !== '0) begin
      errors++; $display("FAIL gap_reset_count: got %0d expected 0", dut.count);
    end
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_reset_discard: got valid=%b expected 0", out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_cut_through();
    do_reset();
    out_ready = 1;
    write_byte(2'd0, 2'd2, 8'h81, 1'b0);
    cycle();
    checks++;
    if ({out_valid, out_payload, out_eop} !== {1'b1, 8'h81, 1'b0}) begin
      errors++; $display("FAIL ct_first: got v=%b p=%h e=%b expected v=1 p=81 e=0",
                         out_valid, out_payload, out_eop);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ct_bubble: got valid=%b expected 0", out_valid);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ct_bubble_hold: got valid=%b expected 0", out_valid);
    end
    write_byte(2'd0, 2'd2, 8'h82, 1'b1);
    checks++;
    if ({out_valid, out_payload, out_eop} !== {1'b1, 8'h82, 1'b1}) begin
      errors++; $display("FAIL ct_resume: got v=%b p=%h e=%b expected v=1 p=82 e=1",
                         out_valid, out_payload, out_eop);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ct_after_eop: got valid=%b expected 0", out_valid);
    end
    out_ready = 0;
  endtask

  // Randomized traffic against a queue model of the buffer contents
  task automatic test_random();
    logic [12:0] mq[$];
    int len = 0;
    bit exp_ovf = 0;
    bit exp_ovs = 0;
    bit wr, last, forced, popping;
    logic [1:0] d, t;
    logic [7:0] data;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      checks++;
      if (host_full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_full c%0d: got %b expected %b", c, host_full, (mq.size() == DEPTH));
      end
      checks++;
      if ({overflow_err, oversize_err} !== {exp_ovf, exp_ovs}) begin
        errors++; $display("FAIL rnd_err c%0d: got ovf=%b ovs=%b expected ovf=%b ovs=%b",
                           c, overflow_err, oversize_err, exp_ovf, exp_ovs);
      end
      checks++;
      if (out_valid) begin
        if (mq.size() == 0) begin
          errors++; $display("FAIL rnd_valid_empty c%0d: got valid=1 expected 0", c);
        end else if ({out_dest_addr, out_packet_type, out_eop, out_payload} !== mq[0]) begin
          errors++; $display("FAIL rnd_data c%0d: got %h expected %h", c,
                             {out_dest_addr, out_packet_type, out_eop, out_payload}, mq[0]);
        end
      end else if ({out_dest_addr, out_packet_type, out_payload, out_eop} !== 13'h0) begin
        errors++; $display("FAIL rnd_idle_zero c%0d: got p=%h expected 0", c, out_payload);
      end
      if (c < 450) begin
        out_ready = ($urandom_range(0, 9) < 6);
        wr = ($urandom_range(0, 1) == 1);
        last = ($urandom_range(0, 9) < 3);
      end else begin
        out_ready = 1;
        wr = (len > 0) && (mq.size() < DEPTH);
        last = 1;
      end
      d = 2'($urandom_range(0, 3));
      t = 2'($urandom_range(0, 3));
      data = 8'($urandom_range(0, 255));
      host_wr = wr; host_dest = d; host_type = t; host_data = data; host_last = last;
      popping = out_valid && out_ready;
      exp_ovf = 0;
      exp_ovs = 0;
      if (wr) begin
        if (mq.size() == DEPTH) begin
          exp_ovf = 1;
        end else begin
          len++;
          forced = (len == MAX_LEN) && !last;
          mq.push_back({d, t, last || forced, data});
          exp_ovs = forced;
          if (last || forced) len = 0;
        end
      end
      if (popping && mq.size() > 0) void'(mq.pop_front());
      cycle();
    end
    host_wr = 0; host_last = 0;
    checks++;
    if (mq.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rnd_drain: got %0d left valid=%b expected 0 left valid=0",
                         mq.size(), out_valid);
    end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
`ifdef ROUTER_INGRESS_CUT_THROUGH_EN
    test_cut_through();
`else
    test_single_packet();
    test_stall();
    test_oversize();
    test_gap_reset();
`endif
    test_full_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
